// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: detects mispredicts, raises a one-cycle fetch redirect,
// and queues predictor updates in a small FIFO drained over a ready/valid handshake.
module branch_resolve_unit #(
    parameter int BTB_SIZE    = 32,
    parameter int INSTR_LEN   = 5,
    parameter int TARGET_LEN  = 10,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic        ex_taken,
    input  logic [63:0] ex_target,
    input  logic [63:0] ex_pred_next,
    output logic        ex_ready,
    output logic        redirect,
    output logic [63:0] redirect_pc,
    output logic        result_cyc,
    output logic [63:0] result_addr,
    output logic        result,
    output logic [63:0] result_target,
    input  logic        result_ready,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end
    if ((BTB_SIZE < 2) || (INSTR_LEN < 1) || (TARGET_LEN < 1) || (TARGET_LEN > 64)) begin : g_bad_pred
        $error("predictor geometry parameters out of range");
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [63:0] pc_mem     [QUEUE_DEPTH];
    logic        taken_mem  [QUEUE_DEPTH];
    logic [63:0] target_mem [QUEUE_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0] count;
    logic [63:0]      actual_next_p0;
    logic             mispredict_p0, vld_p0, push_p0, pop;

    // Stage p0: resolve the branch and decide accept / redirect / enqueue
    assign actual_next_p0 = ex_taken ? ex_target : ex_pc + 64'd4;
    assign mispredict_p0  = (ex_pred_next != actual_next_p0);
    assign result_cyc     = (count != '0);
    assign pop            = result_cyc && result_ready;
    assign ex_ready       = (count < CNT_W'(QUEUE_DEPTH)) || pop;
    // The cycle redirect is high is the wrong-path shadow; nothing there is accepted.
    assign vld_p0         = ex_valid && ex_ready && !redirect;
    assign push_p0        = vld_p0 && (ex_taken || mispredict_p0);
    assign rd_next        = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push_p0) begin
            pc_mem[wr_ptr]     <= ex_pc;
            taken_mem[wr_ptr]  <= ex_taken;
            target_mem[wr_ptr] <= ex_target;
        end
    end

    // Stage p1: registered redirect, queue state, head-of-queue outputs, counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            result_addr      <= '0;
            result           <= 1'b0;
            result_target    <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect <= vld_p0 && mispredict_p0;
            if (vld_p0 && mispredict_p0)
                redirect_pc <= actual_next_p0;

            if (push_p0)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_next;
            case ({push_p0, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Head register: loaded from the incoming entry when it becomes the head,
            // otherwise from the next stored slot after a pop.
            if (push_p0 && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
                result_addr   <= ex_pc;
                result        <= ex_taken;
                result_target <= ex_target;
            end else if (pop && (count > CNT_W'(1))) begin
                result_addr   <= pc_mem[rd_next];
                result        <= taken_mem[rd_next];
                result_target <= target_mem[rd_next];
            end

            if (vld_p0)
                branch_count <= sat_inc(branch_count);
            if (vld_p0 && mispredict_p0)
                mispredict_count <= sat_inc(mispredict_count);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one task per scenario, inline expected-value checks.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_taken, result_ready;
    logic [63:0] ex_pc, ex_target, ex_pred_next;
    logic        ex_ready, redirect, result_cyc, result;
    logic [63:0] redirect_pc, result_addr, result_target;
    logic [31:0] branch_count, mispredict_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_mc = 0;

    branch_resolve_unit #(.BTB_SIZE(32), .INSTR_LEN(5), .TARGET_LEN(10), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_next(ex_pred_next), .ex_ready(ex_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .result_cyc(result_cyc),
        .result_addr(result_addr), .result(result), .result_target(result_target),
        .result_ready(result_ready), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                         input logic [63:0] pred);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_pred_next = pred;
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (branch_count !== exp_bc || mispredict_count !== exp_mc) begin
            failures++;
            $display("FAIL %s counters: got bc=%0d mc=%0d expected bc=%0d mc=%0d",
                     name, branch_count, mispredict_count, exp_bc, exp_mc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; result_ready = 1'b1;
        drive(64'h100, 1'b1, 64'h500, 64'h0);
        repeat (3) step();
        checks++;
        if ({redirect, result_cyc, result, ex_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags: got redir=%b cyc=%b res=%b rdy=%b expected 0 0 0 1",
                     redirect, result_cyc, result, ex_ready);
        end
        checks++;
        if (redirect_pc !== 64'h0 || result_addr !== 64'h0 || result_target !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: got rpc=%h addr=%h tgt=%h expected zeros",
                     redirect_pc, result_addr, result_target);
        end
        check_counts("reset");
        ex_valid = 1'b0;
        reset = 1'b1;
        step();
        check_counts("reset_release");
    endtask

    task automatic test_not_taken();
        drive(64'h100, 1'b0, 64'h0, 64'h104);
        step();
        ex_valid = 1'b0;
        exp_bc++;
        checks++;
        if (redirect !== 1'b0 || result_cyc !== 1'b0) begin
            failures++;
            $display("FAIL not_taken: got redir=%b cyc=%b expected 0 0", redirect, result_cyc);
        end
        check_counts("not_taken");
    endtask

    task automatic test_mispredict();
        result_ready = 1'b0;
        drive(64'h200, 1'b1, 64'h380, 64'h204);
        step();
        exp_bc++; exp_mc++;
        drive(64'h300, 1'b1, 64'h900, 64'h0);  // wrong-path branch in the shadow cycle
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 64'h380) begin
            failures++;
            $display("FAIL mispredict_redirect: got redir=%b pc=%h expected 1 380",
                     redirect, redirect_pc);
        end
        checks++;
        if (result_cyc !== 1'b1 || result_addr !== 64'h200 || result !== 1'b1 ||
            result_target !== 64'h380) begin
            failures++;
            $display("FAIL mispredict_update: got cyc=%b addr=%h res=%b tgt=%h expected 1 200 1 380",
                     result_cyc, result_addr, result, result_target);
        end
        check_counts("mispredict");
        step();
        ex_valid = 1'b0;
        checks++;
        if (redirect !== 1'b0 || result_addr !== 64'h200) begin
            failures++;
            $display("FAIL shadow: got redir=%b addr=%h expected 0 200", redirect, result_addr);
        end
        check_counts("shadow");
        result_ready = 1'b1;
        step();
        checks++;
        if (result_cyc !== 1'b0) begin
            failures++;
            $display("FAIL mispredict_pop: got cyc=%b expected 0", result_cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] pc;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 64'h1000 + 64'(i * 16);
            drive(pc, 1'b1, pc + 64'h1000, pc + 64'h1000);
            step();
            exp_bc++;
        end
        drive(64'h1040, 1'b1, 64'h2040, 64'h2040);
        checks++;
        if (ex_ready !== 1'b0 || result_addr !== 64'h1000) begin
            failures++;
            $display("FAIL full: got rdy=%b addr=%h expected 0 1000", ex_ready, result_addr);
        end
        step();
        check_counts("full_hold");
        result_ready = 1'b1;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_ready: got rdy=%b expected 1", ex_ready);
        end
        step();
        ex_valid = 1'b0;
        exp_bc++;
        check_counts("full_push_pop");
        for (int i = 1; i < 5; i++) begin
            pc = 64'h1000 + 64'(i * 16);
            checks++;
            if (result_cyc !== 1'b1 || result_addr !== pc || result_target !== pc + 64'h1000) begin
                failures++;
                $display("FAIL order_%0d: got cyc=%b addr=%h tgt=%h expected 1 %h %h",
                         i, result_cyc, result_addr, result_target, pc, pc + 64'h1000);
            end
            step();
        end
        checks++;
        if (result_cyc !== 1'b0) begin
            failures++;
            $display("FAIL drained: got cyc=%b expected 0", result_cyc);
        end
    endtask

    task automatic test_wrap();
        drive(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 64'h0);
        step();
        exp_bc++;
        checks++;
        if (redirect !== 1'b0 || result_cyc !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ok: got redir=%b cyc=%b expected 0 0", redirect, result_cyc);
        end
        drive(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 64'h1000);
        step();
        ex_valid = 1'b0;
        exp_bc++; exp_mc++;
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 64'h0) begin
            failures++;
            $display("FAIL wrap_redirect: got redir=%b pc=%h expected 1 0", redirect, redirect_pc);
        end
        checks++;
        if (result_cyc !== 1'b1 || result_addr !== 64'hFFFF_FFFF_FFFF_FFFC || result !== 1'b0) begin
            failures++;
            $display("FAIL wrap_update: got cyc=%b addr=%h res=%b expected 1 fffffffffffffffc 0",
                     result_cyc, result_addr, result);
        end
        check_counts("wrap");
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] pc;
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 64'h5000 + 64'(i * 16);
            drive(pc, 1'b1, pc + 64'h100, pc + 64'h100);
            step();
            exp_bc++;
            checks++;
            if (result_cyc !== 1'b1 || result_addr !== pc) begin
                failures++;
                $display("FAIL b2b_%0d: got cyc=%b addr=%h expected 1 %h",
                         i, result_cyc, result_addr, pc);
            end
        end
        ex_valid = 1'b0;
        step();
        checks++;
        if (result_cyc !== 1'b0 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got cyc=%b redir=%b expected 0 0", result_cyc, redirect);
        end
        check_counts("b2b");
    endtask

    task automatic test_saturation();
        force dut.branch_count = 32'hFFFF_FFFF;
        force dut.mispredict_count = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count;
        release dut.mispredict_count;
        drive(64'h600, 1'b0, 64'h0, 64'h0);
        step();
        ex_valid = 1'b0;
        exp_bc = 32'hFFFF_FFFF; exp_mc = 32'hFFFF_FFFF;
        check_counts("saturation");
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 64'h604) begin
            failures++;
            $display("FAIL sat_redirect: got redir=%b pc=%h expected 1 604", redirect, redirect_pc);
        end
        step();
    endtask

    task automatic test_midreset();
        result_ready = 1'b0;
        drive(64'h7000, 1'b1, 64'h7100, 64'h7100);
        step();
        drive(64'h7010, 1'b1, 64'h7200, 64'h0);
        step();
        ex_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        exp_bc = 0; exp_mc = 0;
        checks++;
        if ({redirect, result_cyc, ex_ready} !== 3'b001 || result_addr !== 64'h0) begin
            failures++;
            $display("FAIL midreset: got redir=%b cyc=%b rdy=%b addr=%h expected 0 0 1 0",
                     redirect, result_cyc, ex_ready, result_addr);
        end
        check_counts("midreset");
        step();
        reset = 1'b1;
    endtask

    initial begin
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0; ex_pred_next = '0;
        result_ready = 1'b0; reset = 1'b0;
        test_reset();
        test_not_taken();
        test_mispredict();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_saturation();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
